// File: rtl/mp_add_if.sv
// Request/response handshake bundle for mp_add_sequencer.
// MP_ADD_SUB_EN adds the req_sub request field.
interface mp_add_if #(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
);
    localparam int N = WIDTH * WORDS;

    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;
`ifdef MP_ADD_SUB_EN
    logic         req_sub;
`endif
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_sum;
    logic         rsp_cout;
    logic         rsp_zero;

    modport master (
        output req_valid, req_a, req_b,
`ifdef MP_ADD_SUB_EN
        output req_sub,
`endif
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_zero
    );

    modport slave (
        input  req_valid, req_a, req_b,
`ifdef MP_ADD_SUB_EN
        input  req_sub,
`endif
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_zero
    );
endinterface

// File: rtl/mp_add_sequencer.sv
// Word-serial multi-precision adder: one WIDTH-bit slice, LS word first, carry chained in a register.
// Define MP_ADD_SUB_EN to add subtract support (req_sub).
module mp_add_sequencer #(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    mp_add_if.slave bus,
    output logic    busy
);
    localparam int N  = WIDTH * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   op_a, op_b, sum_q, sum_upd;
    logic [IW-1:0]  idx;
    logic           carry, cout_q, zero_q;
    logic           accept;
    logic [WIDTH-1:0] a_w, b_w, s_w;
    logic           c_w;
`ifdef MP_ADD_SUB_EN
    logic           sub_q;
`endif

    assign accept = (state_q == IDLE) && bus.req_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = accept ? RUN : IDLE;
            RUN:     state_d = (idx == LAST) ? DONE : RUN;
            DONE:    state_d = bus.rsp_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // Word slice; subtraction is A + ~B + 1 with the +1 seeded into carry at accept.
    always_comb begin
        a_w = op_a[idx*WIDTH +: WIDTH];
        b_w = op_b[idx*WIDTH +: WIDTH];
`ifdef MP_ADD_SUB_EN
        b_w = b_w ^ {WIDTH{sub_q}};
`endif
        {c_w, s_w} = {1'b0, a_w} + {1'b0, b_w} + {{WIDTH{1'b0}}, carry};
        sum_upd = sum_q;
        sum_upd[idx*WIDTH +: WIDTH] = s_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            sum_q  <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            zero_q <= 1'b0;
`ifdef MP_ADD_SUB_EN
            sub_q  <= 1'b0;
`endif
        end else if (accept) begin
            op_a   <= bus.req_a;
            op_b   <= bus.req_b;
            sum_q  <= '0;
            idx    <= '0;
            zero_q <= 1'b0;
`ifdef MP_ADD_SUB_EN
            sub_q  <= bus.req_sub;
            carry  <= bus.req_sub;
`else
            carry  <= 1'b0;
`endif
        end else if (state_q == RUN) begin
            sum_q <= sum_upd;
            carry <= c_w;
            if (idx == LAST) begin
                cout_q <= c_w;
                zero_q <= (sum_upd == '0);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == DONE);
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = cout_q;
    assign bus.rsp_zero  = zero_q;
    assign busy          = (state_q == RUN) || (state_q == DONE);
endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed bench for mp_add_sequencer (WIDTH=8, WORDS=4), hand-computed expectations.
module tb_mp_add_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   n_chk = 0;
    int   n_pass = 0;
    int   lat;
    logic [31:0] held;

    mp_add_if #(.WIDTH(8), .WORDS(4)) bus ();

    mp_add_sequencer #(.WIDTH(8), .WORDS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Present a request (called just after an edge) and return once it is accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic rdy;
        int   n;
        bus.req_valid = 1'b1;
        bus.req_a = a;
        bus.req_b = b;
`ifdef MP_ADD_SUB_EN
        bus.req_sub = sub;
`else
        if (sub) $display("note: subtract requested in add-only build");
`endif
        n = 0;
        do begin
            rdy = bus.req_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) chk("accept_timeout", 0, 1);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int l);
        l = 0;
        while (!bus.rsp_valid && l < 20) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic release_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
`ifdef MP_ADD_SUB_EN
        bus.req_sub = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", bus.rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_sum", bus.rsp_sum, 0);
        chk("rst_cout", bus.rsp_cout, 0);
        chk("rst_zero", bus.rsp_zero, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // carry propagation across a word boundary, latency 4
        send(32'h0000_00FF, 32'h0000_0001, 1'b0);
        chk("run_busy", busy, 1);
        chk("run_ready", bus.req_ready, 0);
        wait_rsp(lat);
        chk("cp_latency", lat, 4);
        chk("cp_sum", bus.rsp_sum, 32'h0000_0100);
        chk("cp_cout", bus.rsp_cout, 0);
        chk("cp_zero", bus.rsp_zero, 0);
        release_rsp();
        chk("cp_valid_drop", bus.rsp_valid, 0);
        chk("cp_hold_sum", bus.rsp_sum, 32'h0000_0100);

        // full wrap; second request held during RUN/DONE with changed operand bus
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_a = 32'h1234_5678;
        bus.req_b = 32'h1111_1111;
        wait_rsp(lat);
        chk("fw_latency", lat, 4);
        chk("fw_sum", bus.rsp_sum, 32'h0000_0000);
        chk("fw_cout", bus.rsp_cout, 1);
        chk("fw_zero", bus.rsp_zero, 1);
        held = bus.rsp_sum;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_sum", bus.rsp_sum, 32'h0000_0000);
            chk("bp_ready", bus.req_ready, 0);
        end
        chk("bp_held", bus.rsp_sum, held);
        release_rsp();
        chk("hs_idle_ready", bus.req_ready, 1);
        chk("hs_idle_busy", busy, 0);
        chk("hs_valid", bus.rsp_valid, 0);
        @(posedge clk); #1;
        chk("second_accept", busy, 1);
        bus.req_valid = 1'b0;
        wait_rsp(lat);
        chk("sec_latency", lat, 4);
        chk("sec_sum", bus.rsp_sum, 32'h2345_6789);
        chk("sec_cout", bus.rsp_cout, 0);
        chk("sec_zero", bus.rsp_zero, 0);
        release_rsp();

        // reset two edges into RUN
        send(32'hAAAA_AAAA, 32'h1111_1111, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", bus.rsp_valid, 0);
        chk("mrst_sum", bus.rsp_sum, 0);
        chk("mrst_ready", bus.req_ready, 1);
        chk("mrst_busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send(32'h0000_0003, 32'h0000_0004, 1'b0);
        wait_rsp(lat);
        chk("post_latency", lat, 4);
        chk("post_sum", bus.rsp_sum, 32'h0000_0007);
        release_rsp();

`ifdef MP_ADD_SUB_EN
        send(32'h0000_0000, 32'h0000_0001, 1'b1);
        wait_rsp(lat);
        chk("sub_sum", bus.rsp_sum, 32'hFFFF_FFFF);
        chk("sub_cout", bus.rsp_cout, 0);
        release_rsp();
        send(32'h0000_0005, 32'h0000_0005, 1'b1);
        wait_rsp(lat);
        chk("sub_eq_sum", bus.rsp_sum, 0);
        chk("sub_eq_zero", bus.rsp_zero, 1);
        chk("sub_eq_cout", bus.rsp_cout, 1);
        release_rsp();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mp_add_sequencer.md
Name: mp_add_sequencer

Overview:
- Multi-precision adder controller. It adds two WORDS×WIDTH-bit operands using one WIDTH-bit adder slice with carry-in.
- One word is processed per clock, least-significant word first, with the carry chained in a register between cycles.
- It sits between a requesting unit (ALU or microcode sequencer) and the arithmetic datapath, and uses valid/ready handshakes on both request and response sides.

Parameters:
- WIDTH, 8, bits per adder slice / word.
- WORDS, 4, number of words per operand (≥1); total operand width N = WIDTH*WORDS.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_a  in  N  operand A.
- req_b  in  N  operand B.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_sum  out  N  result.
- rsp_cout  out  1  carry out of the most-significant word.
- rsp_zero  out  1  high when rsp_sum == 0.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset is asynchronous (rst_n low) and active-low; clock is clk.
- Reset state is IDLE; counter idx=0; carry=0.
- Reset values: rsp_sum=0, rsp_cout=0, rsp_zero=0, rsp_valid=0, busy=0, req_ready=1.
- States: IDLE, RUN, DONE. Encoding is free. Unreachable encodings return to IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready at an edge: capture req_a/req_b into operand registers; clear rsp_sum, carry and idx; go to RUN.
  - rsp_zero is cleared on accept.
- RUN:
  - req_ready=0.
  - Each edge: {c, s} = A[idx] + B[idx] + carry (WIDTH+1-bit result); rsp_sum word idx <= s; carry <= c; idx <= idx+1.
  - On the edge where idx==WORDS-1: rsp_cout <= c; rsp_zero <= (full sum == 0, including word just written); go to DONE.
- DONE:
  - rsp_valid=1; rsp_sum, rsp_cout and rsp_zero are held stable.
  - On rsp_ready high at an edge: go to IDLE; rsp_valid drops next cycle. Result registers keep their value.
- Latency: rsp_valid is high exactly WORDS edges after the accepting edge. Throughput is one request per WORDS+2 cycles when rsp_ready is held high.
- WORDS==1 is legal: RUN lasts one edge.
- req_valid during RUN/DONE is ignored (not captured); the requester must hold it until req_ready.
- Operand registers are private. Changes on req_a/req_b after acceptance have no effect.
- idx width is clog2(WORDS), minimum 1 bit. idx never exceeds WORDS-1 and does not wrap mid-operation.
- Reset mid-operation (RUN or DONE) returns immediately to IDLE with reset values; any partial result is discarded.
- rsp_ready while not in DONE is ignored.
- No combinational path from req_* or rsp_ready to any output. All outputs are registered or decoded from state.

Optional Feature:
- Macro: MP_ADD_SUB_EN.
- Defined:
  - Adds input port req_sub (1 bit), captured with the operands.
  - When captured high: B words are bit-inverted before the slice, and carry is initialised to 1, so rsp_sum = A − B mod 2^N.
  - rsp_cout = 1 means no borrow (A ≥ B unsigned).
- Undefined:
  - req_sub port does not exist; addition only; carry initialised to 0.

Test Plan (WIDTH=8, WORDS=4):
- Reset: assert rst_n low, release -> rsp_valid=0, busy=0, req_ready=1, rsp_sum=0x00000000, rsp_cout=0.
- Carry propagation:
  - A=0x000000FF, B=0x00000001 -> rsp_sum=0x00000100, rsp_cout=0, rsp_zero=0.
  - rsp_valid rises exactly 4 edges after accept.
- Full wrap: A=0xFFFFFFFF, B=0x00000001 -> rsp_sum=0x00000000, rsp_cout=1, rsp_zero=1.
- Backpressure and busy:
  - Hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid stays 1 and rsp_sum is unchanged.
  - A second req_valid held during RUN/DONE is not accepted until one cycle after rsp_ready handshake; the second result is correct (0x12345678+0x11111111=0x23456789).
- Reset mid-operation: pull rst_n low 2 edges after accept -> immediately IDLE, rsp_valid=0, rsp_sum=0. A following request 0x00000003+0x00000004 returns 0x00000007.
- MP_ADD_SUB_EN defined:
  - req_sub=1, A=0x00000000, B=0x00000001 -> rsp_sum=0xFFFFFFFF, rsp_cout=0.
  - req_sub=1, A=5, B=5 -> rsp_sum=0, rsp_zero=1, rsp_cout=1.
